axi_dma_sg_sched: RTL and testbench

Scatter-gather sequencer for the AXI DMA core. On a DMA trigger it pops descriptors (host address, length-1) from the SG descriptor stream filled by the register block. It splits each descriptor into burst-aligned transfer commands for the data mover and advances the FPGA-side address. It tracks outstanding commands, collects completion responses, and drives busy, the 4-bit response status and the interrupt.

---
 rtl/axi_dma_pkg.sv | 14 +
 rtl/axi_dma_burst_split.sv | 20 ++
 rtl/axi_dma_sg_sched.sv | 172 +++++++++++++++++
 tb/tb_axi_dma_sg_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the AXI DMA scatter-gather scheduler.
package axi_dma_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, FLUSH} state_e;

  localparam int RESP_AXI_LO = 0;
  localparam int RESP_AXI_HI = 1;
  localparam int RESP_EMPTY  = 2;
  localparam int RESP_WRAP   = 3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/axi_dma_burst_split.sv
// Combinational chunk calculator: largest command that stays inside one
// MAX_BURST-aligned window, plus a flag for the descriptor's final chunk.
module axi_dma_burst_split #(
  parameter  int MAX_BURST = 2048,
  localparam int LB        = $clog2(MAX_BURST),
  localparam int CW        = LB + 1
) (
  input  logic [LB-1:0] host_off,
  input  logic [16:0]   remaining,
  output logic [CW-1:0] chunk,
  output logic          last
);
  logic [CW-1:0] room;

  always_comb begin
    room  = CW'(MAX_BURST) - {1'b0, host_off};
    last  = remaining <= 17'(room);
    chunk = last ? remaining[CW-1:0] : room;
  end
endmodule

// File: rtl/axi_dma_sg_sched.sv
// Scatter-gather sequencer: pops descriptors, issues burst-aligned mover
// commands, tracks completions. AXI_DMA_SG_SCHED_STATS_EN adds byte/cycle stats.
module axi_dma_sg_sched
  import axi_dma_pkg::*;
#(
  parameter int C_FPGA_ADDR_WIDTH = 32,
  parameter int C_HOST_ADDR_WIDTH = 64,
  parameter int C_MAX_BURST_BYTES = 2048,
  parameter int C_MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(C_MAX_BURST_BYTES) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dma_trigger,
  input  logic                         dma_direction,
  input  logic [C_FPGA_ADDR_WIDTH-1:0] dma_fpga_addr,
  input  logic                         irq_en,
  input  logic                         irq_clr,
  output logic                         busy,
  output logic [3:0]                   response,
  output logic                         irq,
  input  logic [C_HOST_ADDR_WIDTH+15:0] s_axis_sg_tdata,
  input  logic                         s_axis_sg_tvalid,
  output logic                         s_axis_sg_tready,
  output logic [C_HOST_ADDR_WIDTH-1:0] cmd_host_addr,
  output logic [C_FPGA_ADDR_WIDTH-1:0] cmd_fpga_addr,
  output logic [CW-1:0]                cmd_bytes,
  output logic                         cmd_dir,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  input  logic                         done_valid,
  input  logic [1:0]                   done_resp
`ifdef AXI_DMA_SG_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_bytes,
  output logic [31:0]                  stat_cycles
`endif
);
  localparam int FW = C_FPGA_ADDR_WIDTH;
  localparam int HW = C_HOST_ADDR_WIDTH;

  state_e          state_q, state_d;
  logic            dir_q, err_q, pend_q, irq_q;
  logic [FW-1:0]   fpga_q;
  logic [HW-1:0]   host_q;
  logic [16:0]     rem_q;
  logic [3:0]      outst_q;
  logic [3:0]      resp_q;
  logic [CW-1:0]   chunk;
  logic            last, trig, fin, hs, done_ok;
  logic [FW:0]     fpga_sum;

  axi_dma_burst_split #(.MAX_BURST(C_MAX_BURST_BYTES)) u_split (
    .host_off  (host_q[CW-2:0]),
    .remaining (rem_q),
    .chunk     (chunk),
    .last      (last)
  );

  assign trig     = (state_q == IDLE) && dma_trigger;
  assign hs       = cmd_valid && cmd_ready;
  assign done_ok  = done_valid && (outst_q != 4'd0);
  assign fpga_sum = {1'b0, fpga_q} + (FW+1)'(chunk);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    s_axis_sg_tready = 1'b0;
    cmd_valid        = 1'b0;
    fin              = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig && s_axis_sg_tvalid) state_d = FETCH;
        else if (trig)                fin     = 1'b1;
      end
      FETCH: begin
        s_axis_sg_tready = s_axis_sg_tvalid;
        state_d          = s_axis_sg_tvalid ? ISSUE : DRAIN;
      end
      ISSUE: begin
        cmd_valid = !err_q && (outst_q < 4'(C_MAX_OUTSTANDING));
        if (err_q)                         state_d = DRAIN;
        else if (cmd_valid && cmd_ready && last) state_d = FETCH;
      end
      DRAIN: begin
        if (outst_q == 4'd0) begin
          if (err_q) state_d = FLUSH;
          else begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        s_axis_sg_tready = s_axis_sg_tvalid;
        if (!s_axis_sg_tvalid) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q   <= 1'b0;
      fpga_q  <= '0;
      host_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (trig) begin
        dir_q  <= dma_direction;
        fpga_q <= dma_fpga_addr;
        err_q  <= 1'b0;
        resp_q <= s_axis_sg_tvalid ? 4'b0000 : 4'(1 << RESP_EMPTY);
      end
      if (s_axis_sg_tready && state_q == FETCH) begin
        host_q <= s_axis_sg_tdata[HW+15:16];
        rem_q  <= {1'b0, s_axis_sg_tdata[15:0]} + 17'd1;
      end
      if (hs) begin
        host_q <= host_q + HW'(chunk);
        fpga_q <= fpga_sum[FW-1:0];
        rem_q  <= rem_q - 17'(chunk);
        if (fpga_sum[FW]) resp_q[RESP_WRAP] <= 1'b1;
      end
      // A completion in the same cycle as an issue cancels out.
      if (hs && !done_ok)      outst_q <= outst_q + 4'd1;
      else if (!hs && done_ok) outst_q <= outst_q - 4'd1;
      if (done_ok && done_resp != OKAY && !err_q) begin
        err_q                           <= 1'b1;
        resp_q[RESP_AXI_HI:RESP_AXI_LO] <= done_resp;
      end
      if (fin)          pend_q <= 1'b1;
      else if (irq_clr) pend_q <= 1'b0;
      irq_q <= pend_q & irq_en;
    end
  end

  assign busy          = state_q != IDLE;
  assign response      = resp_q;
  assign irq           = irq_q;
  assign cmd_host_addr = host_q;
  assign cmd_fpga_addr = fpga_q;
  assign cmd_bytes     = chunk;
  assign cmd_dir       = dir_q;

`ifdef AXI_DMA_SG_SCHED_STATS_EN
  logic [32:0] bytes_sum;
  assign bytes_sum = {1'b0, stat_bytes} + 33'(chunk);

  always_ff @(posedge clk) begin
    if (!rst_n || trig) begin
      stat_bytes  <= '0;
      stat_cycles <= '0;
    end else begin
      if (hs) stat_bytes <= bytes_sum[32] ? '1 : bytes_sum[31:0];
      if (busy && stat_cycles != '1) stat_cycles <= stat_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_dma_sg_sched.sv
// Directed bench for axi_dma_sg_sched: descriptor source, mover model with
// programmable completion delay/error, and a command scoreboard.
module tb_axi_dma_sg_sched;
  import axi_dma_pkg::*;

  typedef struct {
    logic [63:0] host;
    logic [31:0] fpga;
    logic [11:0] bytes;
    logic        dir;
  } cmd_t;

  logic        clk, rst_n;
  logic        dma_trigger, dma_direction, irq_en, irq_clr;
  logic [31:0] dma_fpga_addr;
  logic        busy, irq;
  logic [3:0]  response;
  logic [79:0] s_axis_sg_tdata;
  logic        s_axis_sg_tvalid, s_axis_sg_tready;
  logic [63:0] cmd_host_addr;
  logic [31:0] cmd_fpga_addr;
  logic [11:0] cmd_bytes;
  logic        cmd_dir, cmd_valid, cmd_ready;
  logic        done_valid;
  logic [1:0]  done_resp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ncmd = 0;
  int done_delay = 3;
  int err_at = -1;
  logic [79:0] sg_q[$];
  cmd_t        sb[$];
  int          due[$];
  logic [1:0]  rsp[$];

  axi_dma_sg_sched dut (
    .clk(clk), .rst_n(rst_n),
    .dma_trigger(dma_trigger), .dma_direction(dma_direction), .dma_fpga_addr(dma_fpga_addr),
    .irq_en(irq_en), .irq_clr(irq_clr),
    .busy(busy), .response(response), .irq(irq),
    .s_axis_sg_tdata(s_axis_sg_tdata), .s_axis_sg_tvalid(s_axis_sg_tvalid),
    .s_axis_sg_tready(s_axis_sg_tready),
    .cmd_host_addr(cmd_host_addr), .cmd_fpga_addr(cmd_fpga_addr), .cmd_bytes(cmd_bytes),
    .cmd_dir(cmd_dir), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done_valid(done_valid), .done_resp(done_resp)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push_desc(input logic [63:0] host, input logic [15:0] lenm1);
    sg_q.push_back({host, lenm1});
  endtask

  task automatic push_cmd(input logic [63:0] host, input logic [31:0] fpga,
                          input logic [11:0] bytes, input logic dir);
    cmd_t c;
    c.host = host; c.fpga = fpga; c.bytes = bytes; c.dir = dir;
    sb.push_back(c);
  endtask

  task automatic start(input logic dir, input logic [31:0] fa);
    dma_direction = dir;
    dma_fpga_addr = fa;
    dma_trigger   = 1'b1;
    tick();
    dma_trigger   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    tick();
  endtask

  // Descriptor source, command scoreboard and mover model in one process.
  initial begin
    logic pop_sg;
    cmd_t c;
    done_valid = 0; done_resp = OKAY;
    s_axis_sg_tvalid = 0; s_axis_sg_tdata = '0;
    forever begin
      @(negedge clk);
      pop_sg = s_axis_sg_tvalid && s_axis_sg_tready;
      if (cmd_valid && cmd_ready) begin
        ncmd++;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          c = sb.pop_front();
          check("cmd_host", cmd_host_addr, c.host);
          check("cmd_fpga", 64'(cmd_fpga_addr), 64'(c.fpga));
          check("cmd_bytes", 64'(cmd_bytes), 64'(c.bytes));
          check("cmd_dir", 64'(cmd_dir), 64'(c.dir));
        end
        due.push_back(cyc + done_delay);
        rsp.push_back(ncmd == err_at ? SLVERR : OKAY);
      end
      @(posedge clk);
      #1;
      if (pop_sg && sg_q.size() != 0) void'(sg_q.pop_front());
      s_axis_sg_tvalid = sg_q.size() != 0;
      s_axis_sg_tdata  = (sg_q.size() != 0) ? sg_q[0] : '0;
      done_valid = 1'b0;
      if (due.size() != 0 && due[0] <= cyc) begin
        done_valid = 1'b1;
        done_resp  = rsp.pop_front();
        void'(due.pop_front());
      end
    end
  end

  initial begin
    int base;
    int n;
    rst_n = 0; dma_trigger = 0; dma_direction = 0; dma_fpga_addr = '0;
    irq_en = 1; irq_clr = 0; cmd_ready = 1;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", 64'(response), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_tready", 64'(s_axis_sg_tready), 64'd0);
    check("rst_cmd_host", cmd_host_addr, 64'd0);
    check("rst_cmd_fpga", 64'(cmd_fpga_addr), 64'd0);
    check("rst_cmd_bytes", 64'(cmd_bytes), 64'd0);
    check("rst_cmd_dir", 64'(cmd_dir), 64'd0);
    rst_n = 1;
    tick();

    // Two full 2 KiB bursts from one 4 KiB descriptor.
    push_desc(64'h1000, 16'h0FFF);
    push_cmd(64'h1000, 32'h000, 12'd2048, 1'b0);
    push_cmd(64'h1800, 32'h800, 12'd2048, 1'b0);
    tick();
    start(1'b0, 32'h0);
    check("t1_busy", 64'(busy), 64'd1);
    wait_idle("t1");
    check("t1_resp", 64'(response), 64'h0);
    tick();
    check("t1_irq", 64'(irq), 64'd1);
    clear_irq();
    check("t1_irq_clr", 64'(irq), 64'd0);

    // Descriptor straddling a burst boundary.
    push_desc(64'h07F0, 16'h001F);
    push_cmd(64'h07F0, 32'h40, 12'd16, 1'b1);
    push_cmd(64'h0800, 32'h50, 12'd16, 1'b1);
    tick();
    start(1'b1, 32'h40);
    wait_idle("t2");
    check("t2_resp", 64'(response), 64'h0);
    clear_irq();

    // Trigger with an empty descriptor stream.
    start(1'b0, 32'h0);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_resp", 64'(response), 64'h4);
    tick();
    check("t3_irq", 64'(irq), 64'd1);
    clear_irq();

    // Outstanding limit with slow completions.
    done_delay = 20;
    push_desc(64'h10000, 16'h0FFF);
    push_desc(64'h20000, 16'h0FFF);
    push_desc(64'h30000, 16'h0FFF);
    for (int i = 0; i < 3; i++) begin
      push_cmd(64'h10000 * (i + 1), 32'h100 + 32'h1000 * i, 12'd2048, 1'b0);
      push_cmd(64'h10000 * (i + 1) + 64'h800, 32'h900 + 32'h1000 * i, 12'd2048, 1'b0);
    end
    tick();
    base = ncmd;
    start(1'b0, 32'h100);
    n = 0;
    while (ncmd - base < 4 && n < 100) begin tick(); n++; end
    check("t4_four_issued", 64'(ncmd - base), 64'd4);
    check("t4_throttle_a", 64'(cmd_valid), 64'd0);
    repeat (5) tick();
    check("t4_throttle_b", 64'(cmd_valid), 64'd0);
    check("t4_still_four", 64'(ncmd - base), 64'd4);
    wait_idle("t4");
    check("t4_all_issued", 64'(ncmd - base), 64'd6);
    check("t4_resp", 64'(response), 64'h0);
    clear_irq();
    done_delay = 3;

    // Error on the second completion; remaining descriptors are flushed.
    push_desc(64'h40000, 16'h3FFF);
    push_desc(64'h50000, 16'h00FF);
    push_desc(64'h60000, 16'h00FF);
    push_cmd(64'h40000, 32'h000, 12'd2048, 1'b0);
    push_cmd(64'h40800, 32'h800, 12'd2048, 1'b0);
    tick();
    base = ncmd;
    err_at = ncmd + 2;
    start(1'b0, 32'h0);
    n = 0;
    while (ncmd - base < 2 && n < 100) begin tick(); n++; end
    cmd_ready = 1'b0;
    n = 0;
    while (response[1:0] == 2'b00 && n < 100) begin tick(); n++; end
    cmd_ready = 1'b1;
    wait_idle("t5");
    check("t5_no_more_cmds", 64'(ncmd - base), 64'd2);
    check("t5_sg_flushed", 64'(sg_q.size()), 64'd0);
    check("t5_resp", 64'(response), 64'h2);
    tick();
    check("t5_irq", 64'(irq), 64'd1);
    err_at = -1;

    // FPGA address wrap; clear held through the completion cycle.
    push_desc(64'h07F0, 16'h001F);
    push_cmd(64'h07F0, 32'hFFFF_FFF0, 12'd16, 1'b0);
    push_cmd(64'h0800, 32'h0000_0000, 12'd16, 1'b0);
    irq_clr = 1'b1;
    tick();
    start(1'b0, 32'hFFFF_FFF0);
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    irq_clr = 1'b0;
    check("t6_idle", 64'(busy), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    check("t6_resp", 64'(response), 64'h8);
    tick();
    check("t6_irq_set_wins", 64'(irq), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
